// File: rtl/fetch_ctrl.sv
// fetch_ctrl -- instruction-fetch sequencer.
//
// Owns the PC, issues one imem request per instruction, waits for the
// response and presents instruction + PC to decode with a valid/stall
// handshake. Branch/jump redirects replace the PC and kill any fetch
// still in flight (the old request still answers; its data is dropped).
//
// Ports
//   clk_i          in   1   clock, rising edge
//   rst_i          in   1   asynchronous reset, active-high
//   stall_i        in   1   decode not ready; hold delivered instruction
//   redirect_i     in   1   take redirect_pc_i as next fetch address
//   redirect_pc_i  in   32  redirect target, bits [1:0] forced to 00
//   imem_req_o     out  1   one-cycle fetch request pulse
//   imem_addr_o    out  32  fetch address while imem_req_o=1, else 0
//   imem_rvalid_i  in   1   imem response valid
//   imem_rdata_i   in   32  imem response data
//   inst_valid_o   out  1   inst_o/pc_o valid for decode
//   inst_o         out  32  fetched instruction
//   pc_o           out  32  PC of inst_o
//   pc_four_o      out  32  pc_o + 4
//   inst_cnt_o     out  32  instructions accepted by decode

// add -- PC incrementer (pc_i + 4, wraps mod 2^32).
module add (
  input  logic [31:0] pc_i,
  output logic [31:0] pc_four_o
);
  assign pc_four_o = pc_i + 32'd4;
endmodule

module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_four_o,
  output logic [31:0] inst_cnt_o
);

  typedef enum logic [1:0] {
    S_BOOT    = 2'd0,
    S_FETCH   = 2'd1,
    S_WAIT    = 2'd2,
    S_DELIVER = 2'd3
  } state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] inst_reg, inst_next;
  logic [31:0] cnt_reg, cnt_next;
  // Set when the outstanding request was overtaken by a redirect; its
  // response must be swallowed rather than delivered.
  logic        kill_reg, kill_next;

  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic [1:0]  unused_target_lsbs;

  assign target             = {redirect_pc_i[31:2], 2'b00};
  assign unused_target_lsbs = redirect_pc_i[1:0];

  add u_add (
    .pc_i      (pc_reg),
    .pc_four_o (pc_plus4)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= S_BOOT;
      pc_reg    <= RESET_PC_ALIGNED;
      inst_reg  <= 32'd0;
      cnt_reg   <= 32'd0;
      kill_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      inst_reg  <= inst_next;
      cnt_reg   <= cnt_next;
      kill_reg  <= kill_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    inst_next  = inst_reg;
    cnt_next   = cnt_reg;
    kill_next  = kill_reg;

    case (state_reg)
      S_BOOT: begin
        // Any response still arriving from before reset is ignored here.
        state_next = S_FETCH;
      end

      S_FETCH: begin
        // A response seen now can only belong to an earlier request.
        state_next = S_WAIT;
        if (redirect_i) begin
          pc_next   = target;
          kill_next = 1'b1;
        end
      end

      S_WAIT: begin
        if (imem_rvalid_i) begin
          if (kill_reg || redirect_i) begin
            kill_next  = 1'b0;
            state_next = S_FETCH;
            if (redirect_i) begin
              pc_next = target;
            end
          end else begin
            inst_next  = imem_rdata_i;
            state_next = S_DELIVER;
          end
        end else if (redirect_i) begin
          pc_next   = target;
          kill_next = 1'b1;
        end
      end

      S_DELIVER: begin
        // Redirect wins over stall; a redirected instruction is not counted.
        if (redirect_i) begin
          pc_next    = target;
          state_next = S_FETCH;
        end else if (!stall_i) begin
          cnt_next   = cnt_reg + 32'd1;
          pc_next    = pc_plus4;
          state_next = S_FETCH;
        end
      end

      default: begin
        state_next = S_BOOT;
      end
    endcase
  end

  assign imem_req_o   = (state_reg == S_FETCH);
  assign imem_addr_o  = (state_reg == S_FETCH) ? pc_reg : 32'd0;
  assign inst_valid_o = (state_reg == S_DELIVER);
  assign inst_o       = inst_reg;
  assign pc_o         = pc_reg;
  assign pc_four_o    = pc_plus4;
  assign inst_cnt_o   = cnt_reg;

endmodule
